// File: rtl/parking_space_controller_pkg.sv
// Shared constants and FSM state encoding for the parking space controller.
package parking_pkg;

    localparam int unsigned SPACES          = 8;
    localparam int unsigned IDX_W           = 3;
    localparam int unsigned GATE_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_REJECT  = 3'd2,
        ST_GATE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

endpackage

// File: rtl/parking_space_controller_free_space_encoder.sv
// Lowest-index free space finder: bit 0 has highest priority.
module free_space_encoder
    import parking_pkg::*;
(
    input  logic [SPACES-1:0] occupancy,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < SPACES; i++) begin
            if (!occupancy[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_space_controller.sv
// Entry/exit sequencer for an 8-space lot; owns the occupancy vector and gate timing.
module parking_space_controller
    import parking_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              entry_req,
    input  logic              exit_valid,
    input  logic [IDX_W-1:0]  exit_space,
    output logic              entry_ack,
    output logic              entry_reject,
    output logic [IDX_W-1:0]  park_number,
    output logic              gate_open,
    output logic              exit_error,
    output logic [SPACES-1:0] occupancy,
    output logic [IDX_W:0]    free_count,
    output logic              full,
    output logic              empty
);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [SPACES-1:0] r_occupancy;
    logic [IDX_W-1:0]  r_park;
    logic              r_ack;
    logic              r_rej;
    logic              r_gate;
    logic              r_err;

    logic [IDX_W-1:0]  w_free_idx;
    logic              w_found;
    logic              w_exit_hit;
    logic [SPACES-1:0] w_exit_mask;
    logic [SPACES-1:0] w_grant_mask;
    logic [IDX_W:0]    w_popcnt;
    logic              w_full;

    free_space_encoder u_enc (
        .occupancy (r_occupancy),
        .idx       (w_free_idx),
        .found     (w_found)
    );

    assign w_exit_hit = exit_valid && r_occupancy[exit_space];
    assign w_full     = &r_occupancy;

    // Grant set and exit clear are independent masks so both can land on the same edge.
    always_comb begin
        w_exit_mask  = '0;
        w_grant_mask = '0;
        if (w_exit_hit) begin
            w_exit_mask[exit_space] = 1'b1;
        end
        if (r_state == ST_GRANT) begin
            w_grant_mask[r_park] = 1'b1;
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int unsigned i = 0; i < SPACES; i++) begin
            w_popcnt = w_popcnt + {{IDX_W{1'b0}}, r_occupancy[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_occupancy <= '0;
            r_park      <= '0;
            r_ack       <= 1'b0;
            r_rej       <= 1'b0;
            r_gate      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack       <= 1'b0;
            r_rej       <= 1'b0;
            r_gate      <= 1'b0;
            r_err       <= exit_valid && !r_occupancy[exit_space];
            r_occupancy <= (r_occupancy | w_grant_mask) & ~w_exit_mask;

            case (r_state)
                ST_IDLE: begin
                    if (entry_req) begin
                        if (!w_full) begin
                            r_park  <= w_free_idx;
                            r_state <= ST_GRANT;
                        end else begin
                            r_state <= ST_REJECT;
                        end
                    end
                end
                ST_GRANT: begin
                    r_ack   <= 1'b1;
                    r_cnt   <= 8'(GATE_CYCLES);
                    r_state <= ST_GATE;
                end
                ST_GATE: begin
                    r_gate <= 1'b1;
                    r_cnt  <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_REJECT: begin
                    r_rej   <= 1'b1;
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!entry_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign entry_ack    = r_ack;
    assign entry_reject = r_rej;
    assign park_number  = r_park;
    assign gate_open    = r_gate;
    assign exit_error   = r_err;
    assign occupancy    = r_occupancy;
    assign free_count   = (IDX_W + 1)'(SPACES) - w_popcnt;
    assign full         = w_full;
    assign empty        = ~|r_occupancy;

endmodule

// File: doc/parking_space_controller.md
Name: parking_space_controller

Overview:
- Sequences car entry and exit for an 8-space lot and owns the occupancy vector.
- On an entry request it allocates the lowest-numbered free space, acknowledges it, and holds the gate open for a programmed number of cycles; it rejects the request when the lot is full.
- Exit events free the named space at any time, independent of entry sequencing.
- Sits between the gate/sensor front end and the lot display/indicator logic.

Parameters:
- SPACES, 8: number of parking spaces; index width IDX_W = 3.
- GATE_CYCLES, 4: cycles gate_open stays high after a grant; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- entry_req  input  1  level request from the entry sensor; held until acked or rejected.
- exit_valid  input  1  one-cycle pulse: car leaving space exit_space.
- exit_space  input  3  index of the departing car's space; qualified by exit_valid.
- entry_ack  output  1  one-cycle pulse: space granted, park_number valid.
- entry_reject  output  1  one-cycle pulse: lot full, request refused.
- park_number  output  3  last granted space index; holds until the next grant.
- gate_open  output  1  entry gate drive.
- exit_error  output  1  one-cycle pulse: exit targeted a space that is not occupied.
- occupancy  output  8  bit i = space i occupied.
- free_count  output  4  SPACES minus popcount(occupancy).
- full  output  1  occupancy == 8'hFF.
- empty  output  1  occupancy == 8'h00.

Behaviour:
- Reset (reset_n = 0 at a clk edge) sets outputs and state as follows:
  - occupancy = 0, free_count = 8, empty = 1, full = 0.
  - entry_ack, entry_reject, gate_open, exit_error = 0; park_number = 0.
  - FSM = IDLE; gate counter = 0.
- Reset mid-operation: any state returns to IDLE at that edge, the gate closes immediately, and all occupancy is lost.
- FSM states are IDLE, GRANT, REJECT, GATE and RELEASE.
- IDLE:
  - entry_req = 1 and full = 0: register the lowest-index clear bit of occupancy into park_number, then go to GRANT.
  - entry_req = 1 and full = 1: go to REJECT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle): entry_ack = 1, and occupancy[park_number] is set at the end of the cycle. Next state is GATE with the counter loaded to GATE_CYCLES.
- GATE: gate_open = 1; the counter decrements each cycle. When the count reaches 1, go to RELEASE, so gate_open is high for exactly GATE_CYCLES cycles.
- REJECT (1 cycle): entry_reject = 1, then go to RELEASE.
- RELEASE: wait for entry_req = 0, then return to IDLE. A request dropped early exits RELEASE on its first cycle. No re-grant happens without a low phase on entry_req.
- Latency: entry_req first sampled high in IDLE at edge k gives entry_ack high in the cycle after edge k+1, and gate_open high from edge k+2.
- Allocation uses a snapshot of occupancy taken in IDLE.
  - A space freed by an exit in that same cycle is not eligible until the next request.
  - Only lower-index priority applies; bit 0 wins.
- Exits are processed in every state, including during reset release cycles after reset_n = 1.
  - exit_valid with occupancy[exit_space] = 1 clears that bit at the edge.
  - exit_valid with occupancy[exit_space] = 0 pulses exit_error for one cycle with no state change. This includes the space currently in GRANT but not yet set.
- Simultaneous grant set and exit clear on different bits in the same cycle: both take effect.
- free_count, full and empty are combinational from the registered occupancy, so they are always consistent with it.
- A full lot becoming non-full while in REJECT/RELEASE does not revive the request; the requester must deassert and reassert.
- All outputs are driven from registers or from occupancy. No X is ever driven, including park_number before the first grant.

Decomposition:
- Shared package parking_pkg holds:
  - the SPACES and IDX_W constants;
  - the FSM state encoding (3-bit localparams IDLE = 0, GRANT = 1, REJECT = 2, GATE = 3, RELEASE = 4);
  - the GATE_CYCLES default.
- One sub-module, free_space_encoder: combinational lowest-free-index finder. Its input is occupancy and its outputs are idx[2:0] and found. It is the only combinational block instantiated. Popcount stays inline.

Test Plan:
- Reset, then entry_req held high → entry_ack pulse with park_number = 0, gate_open high for 4 cycles, occupancy = 8'h01, free_count = 7.
- Eight sequential requests, each deasserted after ack → park_numbers 0..7 in order; then full = 1, free_count = 0. A ninth request → entry_reject pulse, no ack, gate_open stays 0.
- Lot full; exit_valid with exit_space = 5 → occupancy = 8'hDF. Next request → park_number = 5, full = 1 again.
- exit_valid with exit_space = 3 while space 3 is empty → exit_error single-cycle pulse, occupancy unchanged.
- Occupancy 8'h03, request in IDLE in the same cycle as an exit of space 0 → grant park_number = 2, final occupancy = 8'h06.
- reset_n = 0 asserted during GATE with occupancy 8'h0F → next cycle: gate_open = 0, occupancy = 0, empty = 1, FSM idle. Request honoured after deassert/reassert.
